// File: rtl/vga_scanout_prefetcher.sv
// Burst-fetches a frame buffer over the SRAM controller's VGA read port into a pixel FIFO.
// A burst starts only when FIFO words plus in-flight reads leave room for a whole burst, so returns never overflow.
module vga_scanout_prefetcher #(
  parameter int DEPTH        = 16,
  parameter int BURST        = 8,
  parameter int READ_LATENCY = 2,
  parameter int FRAME_WORDS  = 76800
) (
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic        I_frame_start,
  input  logic [17:0] I_base_addr,
  input  logic        I_enable,
  input  logic        I_rd,
  output logic [15:0] O_dat,
  output logic        O_valid,
  output logic        O_underrun,
  output logic        O_vga_req,
  output logic [17:0] O_vga_adr,
  input  logic [15:0] I_vga_dat
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(BURST + 1);

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t                  state_q;
  logic [17:0]             adr_q;
  logic [17:0]             remaining_q;
  logic [BW-1:0]           beat_q;
  logic [BW-1:0]           beat_d;
  logic                    req_q;
  logic [17:0]             vga_adr_q;
  logic [READ_LATENCY-1:0] pipe_q;
  logic [READ_LATENCY-1:0] pipe_d;
  logic [15:0]             mem_q [DEPTH];
  logic [AW-1:0]           wr_ptr_q;
  logic [AW-1:0]           rd_ptr_q;
  logic [CW-1:0]           fifo_cnt_q;
  logic                    underrun_q;

  logic [31:0] inflight;
  logic [31:0] reserved;
  logic        start_ok;
  logic        push;
  logic        pop;
  logic        fifo_nonempty;

  // Reservation counts both buffered words and reads whose data is still on its way back.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + 32'(pipe_q[i]);
    end
  end

  assign reserved = 32'(fifo_cnt_q) + inflight;
  assign start_ok = I_enable && (remaining_q != '0) && (reserved + 32'(BURST) <= 32'(DEPTH));
  assign beat_d   = (32'(remaining_q) < 32'(BURST)) ? BW'(remaining_q) : BW'(BURST);

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state_q     <= ST_IDLE;
      adr_q       <= '0;
      remaining_q <= '0;
      beat_q      <= '0;
      req_q       <= 1'b0;
      vga_adr_q   <= '0;
    end else if (I_frame_start) begin
      state_q     <= ST_IDLE;
      adr_q       <= I_base_addr;
      remaining_q <= 18'(FRAME_WORDS);
      beat_q      <= '0;
      req_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          req_q <= 1'b0;
          if (start_ok) begin
            state_q <= ST_BURST;
            beat_q  <= beat_d;
          end
        end
        ST_BURST: begin
          if (beat_q != '0) begin
            req_q       <= 1'b1;
            vga_adr_q   <= adr_q;
            adr_q       <= adr_q + 18'd1;
            remaining_q <= remaining_q - 18'd1;
            beat_q      <= beat_q - BW'(1);
          end else begin
            req_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    pipe_d    = pipe_q << 1;
    pipe_d[0] = req_q;
  end

  assign fifo_nonempty = (fifo_cnt_q != '0);
  assign push          = pipe_q[READ_LATENCY-1];
  assign pop           = I_rd && fifo_nonempty;

  // A flush drops the in-flight marks, so data still returning for the old frame is never written.
  always_ff @(posedge I_clk) begin
    if (I_reset || I_frame_start) begin
      pipe_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      underrun_q <= 1'b0;
    end else begin
      pipe_q <= pipe_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
        fifo_cnt_q <= fifo_cnt_q + CW'(1);
      end else if (pop && !push) begin
        fifo_cnt_q <= fifo_cnt_q - CW'(1);
      end
      if (I_rd && !fifo_nonempty) begin
        underrun_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge I_clk) begin
    if (push && !I_reset && !I_frame_start) begin
      mem_q[wr_ptr_q] <= I_vga_dat;
    end
  end

  assign O_dat      = fifo_nonempty ? mem_q[rd_ptr_q] : '0;
  assign O_valid    = fifo_nonempty;
  assign O_underrun = underrun_q;
  assign O_vga_req  = req_q;
  assign O_vga_adr  = vga_adr_q;

endmodule

// File: tb/tb_vga_scanout_prefetcher.sv
// Bench for vga_scanout_prefetcher: SRAM return model at latency 2, pop scoreboards, directed scenarios.
`timescale 1ns/1ps
module tb_vga_scanout_prefetcher;

  logic        clk = 1'b0;
  logic        rst, fs, en, rd, rd10;
  logic [17:0] base;
  logic [15:0] dat, dat10, vdat, vdat10;
  logic        valid, valid10, underrun, underrun10, req, req10;
  logic [17:0] adr, adr10;

  always #5 clk = ~clk;

  vga_scanout_prefetcher u_dut (
    .I_clk(clk), .I_reset(rst), .I_frame_start(fs), .I_base_addr(base), .I_enable(en),
    .I_rd(rd), .O_dat(dat), .O_valid(valid), .O_underrun(underrun),
    .O_vga_req(req), .O_vga_adr(adr), .I_vga_dat(vdat));

  vga_scanout_prefetcher #(.FRAME_WORDS(10)) u_dut10 (
    .I_clk(clk), .I_reset(rst), .I_frame_start(fs), .I_base_addr(base), .I_enable(en),
    .I_rd(rd10), .O_dat(dat10), .O_valid(valid10), .O_underrun(underrun10),
    .O_vga_req(req10), .O_vga_adr(adr10), .I_vga_dat(vdat10));

  // SRAM model: the word at address A is A[15:0], two cycles after the request.
  logic [1:0]  mv = '0;
  logic [17:0] ma1 = '0, ma2 = '0, mb1 = '0, mb2 = '0;
  always @(posedge clk) begin
    mv  <= {mv[0], req};
    ma1 <= adr;
    ma2 <= ma1;
    mb1 <= adr10;
    mb2 <= mb1;
  end
  assign vdat   = ma2[15:0];
  assign vdat10 = mb2[15:0];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [15:0] exp_q[$];
  logic [15:0] exp10_q[$];
  logic [17:0] req_log[$];
  logic [17:0] req10_log[$];
  int          reqs = 0, pops = 0, reqs10 = 0, pops10 = 0;
  logic        prev_req = 1'b0;
  logic        chk_burst = 1'b0;
  logic [15:0] first_pop = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (fs) begin
        reqs = 0; pops = 0; reqs10 = 0; pops10 = 0;
        req_log.delete(); req10_log.delete();
        prev_req = 1'b0;
      end else begin
        if (req) begin
          if (!prev_req && chk_burst) begin
            n_checks++;
            if (reqs - pops > 8) begin
              n_fail++;
              $display("FAIL burst_space: outstanding %0d required <= 8", reqs - pops);
            end
          end
          reqs++;
          req_log.push_back(adr);
        end
        prev_req = req;
        if (req10) begin
          reqs10++;
          req10_log.push_back(adr10);
        end
        if (rd && valid) begin
          if (pops == 0) first_pop = dat;
          if (exp_q.size() == 0) check("pop_data_extra", 32'(dat), 32'hFFFF_FFFF);
          else check("pop_data", 32'(dat), 32'(exp_q.pop_front()));
          pops++;
        end
        if (rd10 && valid10) begin
          if (exp10_q.size() == 0) check("pop10_data_extra", 32'(dat10), 32'hFFFF_FFFF);
          else check("pop10_data", 32'(dat10), 32'(exp10_q.pop_front()));
          pops10++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_pulse(input logic [17:0] b);
    logic [17:0] a;
    fs   = 1'b1;
    base = b;
    exp_q.delete();
    exp10_q.delete();
    for (int i = 0; i < 3000; i++) begin
      a = b + 18'(i);
      exp_q.push_back(a[15:0]);
      if (i < 10) exp10_q.push_back(a[15:0]);
    end
    tick();
    fs = 1'b0;
  endtask

  logic [17:0] wrap_adr [10] = '{18'h3FFFC, 18'h3FFFD, 18'h3FFFE, 18'h3FFFF, 18'h00000,
                                 18'h00001, 18'h00002, 18'h00003, 18'h00004, 18'h00005};

  initial begin
    int beats, guard;
    rst = 1'b1; fs = 1'b0; base = '0; en = 1'b0; rd = 1'b0; rd10 = 1'b0;
    repeat (2) tick();
    check("reset_req", 32'(req), 0);
    check("reset_adr", 32'(adr), 0);
    check("reset_valid", 32'(valid), 0);
    check("reset_underrun", 32'(underrun), 0);
    check("reset_dat", 32'(dat), 0);
    rst = 1'b0;
    en  = 1'b1;

    // Enabled but never started: nothing fetched.
    repeat (100) tick();
    check("idle_reqs", 32'(reqs), 0);
    check("idle_valid", 32'(valid), 0);

    // Fill from 0x00100 with no consumer: two bursts, then full.
    frame_pulse(18'h00100);
    repeat (100) tick();
    check("fill_reqs", 32'(reqs), 16);
    for (int i = 0; i < 16; i++) begin
      if (i < req_log.size()) check("fill_adr", 32'(req_log[i]), 32'h100 + 32'(i));
    end
    check("fill_valid", 32'(valid), 1);
    check("fill_head", 32'(dat), 32'h0100);
    repeat (50) tick();
    check("fill_no_more_reqs", 32'(reqs), 16);

    // Steady drain every 4th cycle.
    chk_burst = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      rd = ((c % 4) == 0);
      tick();
    end
    rd = 1'b0;
    chk_burst = 1'b0;
    check("steady_pops", 32'(pops), 500);
    check("steady_underrun", 32'(underrun), 0);

    // Address wrap on the 10-word frame instance.
    frame_pulse(18'h3FFFC);
    repeat (100) tick();
    check("wrap_reqs", 32'(reqs10), 10);
    for (int i = 0; i < 10; i++) begin
      if (i < req10_log.size()) check("wrap_adr", 32'(req10_log[i]), 32'(wrap_adr[i]));
    end
    check("wrap_req_idle", 32'(req10), 0);
    for (int c = 0; c < 40; c++) begin
      rd10 = ((c % 2) == 0);
      tick();
    end
    rd10 = 1'b0;
    check("wrap_delivered", 32'(pops10), 10);
    check("wrap_empty", 32'(valid10), 0);
    check("wrap_reqs_after", 32'(reqs10), 10);

    // Restart during the 4th beat of a burst.
    frame_pulse(18'h01000);
    beats = 0;
    for (guard = 0; guard < 100 && beats < 4; guard++) begin
      tick();
      if (req) beats++;
    end
    check("beat4_reached", 32'(beats), 4);
    check("preflush_valid", 32'(valid), 1);
    check("preflush_head", 32'(dat), 32'h1000);
    frame_pulse(18'h02000);
    check("flush_valid_t1", 32'(valid), 0);
    tick();
    check("flush_valid_t2", 32'(valid), 0);
    tick();
    check("flush_valid_t3", 32'(valid), 0);
    for (guard = 0; guard < 100 && reqs == 0; guard++) tick();
    check("restart_first_adr", (req_log.size() > 0) ? 32'(req_log[0]) : 32'hFFFF_FFFF, 32'h2000);
    for (int c = 0; c < 200 && pops < 20; c++) begin
      rd = valid;
      tick();
    end
    rd = 1'b0;
    check("restart_pops", 32'(pops), 20);
    check("restart_first_pop", 32'(first_pop), 32'h2000);

    // Drain, then pop while empty.
    en = 1'b0;
    for (int c = 0; c < 100; c++) begin
      rd = valid;
      tick();
    end
    rd = 1'b0;
    check("drained", 32'(valid), 0);
    check("no_underrun_yet", 32'(underrun), 0);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("underrun_set", 32'(underrun), 1);
    check("underrun_dat", 32'(dat), 0);
    repeat (10) tick();
    check("underrun_held", 32'(underrun), 1);
    frame_pulse(18'h03000);
    check("underrun_cleared", 32'(underrun), 0);

    // One burst, pop 3 to reach 5, then pop exactly on a push cycle.
    en = 1'b1;
    tick();
    en = 1'b0;
    repeat (30) tick();
    check("one_burst_cnt", 32'(u_dut.fifo_cnt_q), 8);
    for (int k = 0; k < 3; k++) begin
      rd = 1'b1;
      tick();
    end
    rd = 1'b0;
    check("cnt_five", 32'(u_dut.fifo_cnt_q), 5);
    en = 1'b1;
    for (guard = 0; guard < 50 && !mv[1]; guard++) tick();
    check("push_seen", 32'(mv[1]), 1);
    rd = 1'b1;
    en = 1'b0;
    tick();
    rd = 1'b0;
    check("push_pop_cnt", 32'(u_dut.fifo_cnt_q), 5);
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
